// File: rtl/instr_fetch_buf.sv
// Fetch buffer between the PC and decode: issues reads to a synchronous program
// memory and queues each returned instruction, tagged with its PC, in a small FIFO.
module instr_fetch_buf #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   RST_N,
    input  logic [AW-1:0]          PC_IN,
    input  logic                   PC_VALID,
    output logic                   PC_READY,
    input  logic                   FLUSH,
    output logic [AW-1:0]          MEM_ADDR,
    output logic                   MEM_RD,
    input  logic [DW-1:0]          MEM_DATA,
    output logic [DW-1:0]          IR_OUT,
    output logic [AW-1:0]          IR_PC,
    output logic                   IR_VALID,
    input  logic                   IR_READY,
    output logic [$clog2(DEPTH):0] COUNT
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 2;

    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [MEM_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [AW-1:0]      pipe_tag_q [MEM_LAT];
    logic [AW-1:0]      pipe_tag_d [MEM_LAT];
    logic [DW-1:0]      fifo_instr_q [DEPTH];
    logic [AW-1:0]      fifo_pc_q [DEPTH];
    logic [SW-1:0]      used;
    logic               issue;
    logic               push;
    logic               pop;

    // Credit counts queued entries plus reads still in the memory pipe, so a
    // read is only issued when its result is guaranteed a FIFO slot.
    always_comb begin
        used = SW'(count_q);
        for (int i = 0; i < MEM_LAT; i++) begin
            used = used + SW'(pipe_vld_q[i]);
        end
    end

    assign PC_READY = (used < SW'(DEPTH));
    assign issue    = PC_VALID & PC_READY & ~FLUSH & RST_N;
    assign MEM_RD   = issue;
    assign MEM_ADDR = PC_IN;

    assign IR_VALID = (count_q != '0);
    assign IR_OUT   = IR_VALID ? fifo_instr_q[rd_ptr_q] : '0;
    assign IR_PC    = IR_VALID ? fifo_pc_q[rd_ptr_q] : '0;
    assign COUNT    = count_q;

    assign push = pipe_vld_q[MEM_LAT-1] & ~FLUSH;
    assign pop  = IR_VALID & IR_READY & ~FLUSH;

    always_comb begin
        pipe_vld_d    = '0;
        pipe_tag_d[0] = PC_IN;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
        if (!FLUSH) begin
            pipe_vld_d[0] = issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld_d[i] = pipe_vld_q[i-1];
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (FLUSH) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pipe_vld_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pipe_vld_q <= pipe_vld_d;
        end
    end

    // Tags and FIFO storage carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        pipe_tag_q <= pipe_tag_d;
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= MEM_DATA;
            fifo_pc_q[wr_ptr_q]    <= pipe_tag_q[MEM_LAT-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!RST_N)
        !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_buf.sv
// Bench for instr_fetch_buf: two instances (MEM_LAT=1 and MEM_LAT=3) driven in
// lockstep, checked every cycle against a queue-based model of the fetch rules.
module tb_instr_fetch_buf;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] pc_in;
    logic pc_valid, flush, ir_ready;

    logic          pc_ready [2];
    logic [AW-1:0] mem_addr [2];
    logic          mem_rd   [2];
    logic [DW-1:0] mem_data [2];
    logic [DW-1:0] ir_out   [2];
    logic [AW-1:0] ir_pc    [2];
    logic          ir_valid [2];
    logic [CW-1:0] count    [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int fq [2][$];
    int iq [2][$];
    int it [2][$];
    logic          hv [2][3];
    logic [AW-1:0] ha [2][3];
    logic          iss_s [2];
    logic          ev_s  [2];
    logic          rd_s  [2];
    logic [AW-1:0] ad_s  [2];

    always #5 clk = ~clk;

    instr_fetch_buf #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .RST_N(rst_n), .PC_IN(pc_in), .PC_VALID(pc_valid),
        .PC_READY(pc_ready[0]), .FLUSH(flush), .MEM_ADDR(mem_addr[0]),
        .MEM_RD(mem_rd[0]), .MEM_DATA(mem_data[0]), .IR_OUT(ir_out[0]),
        .IR_PC(ir_pc[0]), .IR_VALID(ir_valid[0]), .IR_READY(ir_ready),
        .COUNT(count[0]));

    instr_fetch_buf #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .RST_N(rst_n), .PC_IN(pc_in), .PC_VALID(pc_valid),
        .PC_READY(pc_ready[1]), .FLUSH(flush), .MEM_ADDR(mem_addr[1]),
        .MEM_RD(mem_rd[1]), .MEM_DATA(mem_data[1]), .IR_OUT(ir_out[1]),
        .IR_PC(ir_pc[1]), .IR_VALID(ir_valid[1]), .IR_READY(ir_ready),
        .COUNT(count[1]));

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Program memory contents: a fixed scramble of the address.
    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0003);
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            fq[i].delete();
            iq[i].delete();
            it[i].delete();
            for (int k = 0; k < 3; k++) begin
                hv[i][k] = 1'b0;
                ha[i][k] = '0;
            end
        end
    endtask

    // One clock cycle: inputs were set by the caller just after the previous edge.
    task automatic cycle();
        int dummy;
        logic exp_rdy;
        for (int i = 0; i < 2; i++) begin
            mem_data[i] = hv[i][lat(i)-1] ? word(ha[i][lat(i)-1]) : $urandom;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_rdy  = (fq[i].size() + iq[i].size()) < DEPTH;
            iss_s[i] = pc_valid & exp_rdy & ~flush;
            ev_s[i]  = (fq[i].size() != 0);
            chk("pc_ready", i, 32'(pc_ready[i]), 32'(exp_rdy));
            chk("mem_rd", i, 32'(mem_rd[i]), 32'(iss_s[i]));
            if (iss_s[i]) chk("mem_addr", i, 32'(mem_addr[i]), 32'(pc_in));
            chk("ir_valid", i, 32'(ir_valid[i]), 32'(ev_s[i]));
            chk("ir_pc", i, 32'(ir_pc[i]), ev_s[i] ? 32'(fq[i][0]) : 32'h0);
            chk("ir_out", i, ir_out[i], ev_s[i] ? word(AW'(fq[i][0])) : 32'h0);
            chk("count", i, 32'(count[i]), 32'(fq[i].size()));
            rd_s[i] = mem_rd[i];
            ad_s[i] = mem_addr[i];
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (flush) begin
                fq[i].delete();
                iq[i].delete();
                it[i].delete();
            end else begin
                if (ev_s[i] && ir_ready) dummy = fq[i].pop_front();
                if (it[i].size() != 0 && it[i][0] + lat(i) == cyc) begin
                    fq[i].push_back(iq[i].pop_front());
                    dummy = it[i].pop_front();
                end
                if (iss_s[i]) begin
                    iq[i].push_back(int'(pc_in));
                    it[i].push_back(cyc);
                end
            end
            for (int k = 2; k > 0; k--) begin
                hv[i][k] = hv[i][k-1];
                ha[i][k] = ha[i][k-1];
            end
            hv[i][0] = rd_s[i];
            ha[i][0] = ad_s[i];
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        pc_valid = 1'b0;
        flush    = 1'b0;
        ir_ready = 1'b1;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        int first_v [2];
        int acc [2];
        int nvalid;

        rst_n = 1'b0; pc_in = '0; pc_valid = 1'b0; flush = 1'b0; ir_ready = 1'b0;
        mem_data[0] = '0; mem_data[1] = '0;
        model_reset();
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ir_valid", i, 32'(ir_valid[i]), 32'h0);
            chk("rst_mem_rd", i, 32'(mem_rd[i]), 32'h0);
            chk("rst_count", i, 32'(count[i]), 32'h0);
            chk("rst_pc_ready", i, 32'(pc_ready[i]), 32'h1);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming: PC 0..3 back to back with decode always ready.
        first_v[0] = -1; first_v[1] = -1; nvalid = 0;
        ir_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 2; i++) if (first_v[i] < 0 && ir_valid[i]) first_v[i] = k;
            if (k >= 2 && k <= 5 && ir_valid[0]) nvalid++;
            pc_valid = (k < 4);
            pc_in    = AW'(k);
            cycle();
        end
        chk("lat1_first_valid", 0, 32'(first_v[0]), 32'd2);
        chk("lat3_first_valid", 1, 32'(first_v[1]), 32'd4);
        chk("lat1_no_bubbles", 0, 32'(nvalid), 32'd4);

        // Backpressure: decode stalled, PC offered continuously.
        idle(4);
        acc[0] = 0; acc[1] = 0;
        ir_ready = 1'b0;
        pc_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pc_in = AW'($urandom);
            for (int i = 0; i < 2; i++) if (pc_ready[i]) acc[i]++;
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            chk("bp_accepts", i, 32'(acc[i]), 32'd4);
            chk("bp_count_full", i, 32'(count[i]), 32'd4);
            chk("bp_pc_ready_low", i, 32'(pc_ready[i]), 32'h0);
        end
        pc_valid = 1'b0;
        ir_ready = 1'b1;
        cycle();
        chk("bp_pc_ready_back", 0, 32'(pc_ready[0]), 32'h1);
        idle(6);

        // Flush with two entries queued and one read in flight.
        ir_ready = 1'b0;
        pc_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pc_in = AW'($urandom);
            cycle();
        end
        chk("fl_count_pre", 0, 32'(count[0]), 32'd2);
        pc_valid = 1'b0;
        flush    = 1'b1;
        cycle();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("fl_ir_valid", i, 32'(ir_valid[i]), 32'h0);
            chk("fl_count", i, 32'(count[i]), 32'h0);
        end
        pc_in    = AW'(10'h1F0);
        pc_valid = 1'b1;
        cycle();
        pc_valid = 1'b0;
        ir_ready = 1'b1;
        for (int k = 1; k < 6; k++) begin
            if (k == 2) chk("fl_first_pc", 0, 32'(ir_pc[0]), 32'h1F0);
            if (k == 4) chk("fl_first_pc", 1, 32'(ir_pc[1]), 32'h1F0);
            cycle();
        end

        // Push and pop together at COUNT=2, long enough to wrap the pointers.
        idle(4);
        ir_ready = 1'b0;
        pc_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pc_in = AW'($urandom);
            cycle();
        end
        ir_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            chk("pp_count_steady", 0, 32'(count[0]), 32'd2);
            pc_in = AW'($urandom);
            cycle();
        end

        // Continuous fetch on both latencies.
        idle(6);
        first_v[1] = -1;
        pc_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (first_v[1] < 0 && ir_valid[1]) first_v[1] = k;
            pc_in = AW'($urandom);
            cycle();
        end
        chk("cont_lat3_first_valid", 1, 32'(first_v[1]), 32'd4);

        // Randomized traffic with occasional flushes.
        for (int k = 0; k < 400; k++) begin
            pc_valid = ($urandom_range(0, 3) != 0);
            ir_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            pc_in    = AW'($urandom);
            cycle();
        end

        // Asynchronous reset in the middle of a cycle with work queued.
        flush    = 1'b0;
        ir_ready = 1'b0;
        pc_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pc_in = AW'($urandom);
            cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("mid_rst_ir_valid", i, 32'(ir_valid[i]), 32'h0);
            chk("mid_rst_mem_rd", i, 32'(mem_rd[i]), 32'h0);
            chk("mid_rst_count", i, 32'(count[i]), 32'h0);
            chk("mid_rst_pc_ready", i, 32'(pc_ready[i]), 32'h1);
        end
        model_reset();
        pc_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        ir_ready = 1'b1;
        pc_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            pc_in = AW'($urandom);
            cycle();
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
